// File: rtl/inst_mem_sync.sv
// Synchronous instruction memory with a one-cycle registered fetch stage.
// A loader port writes words. The fetch port reads one word per cycle and
// supports stall and flush. Misaligned or out-of-range fetches produce a
// faulting bubble. An accepted-fetch counter saturates at its maximum.
module inst_mem_sync #(
    parameter int                 ADDR_W          = 6,
    parameter int                 DATA_W          = 32,
    parameter logic [DATA_W-1:0]  NOP_WORD        = 32'h00000013,
    // Value the fetch counter returns to on reset. It is left at zero in
    // normal use and raised only to exercise saturation quickly.
    parameter logic [31:0]        FETCH_COUNT_RST = 32'h00000000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_fetch_req,
    input  logic [31:0]       i_fetch_addr,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic              i_prog_we,
    input  logic [ADDR_W-1:0] i_prog_addr,
    input  logic [DATA_W-1:0] i_prog_data,
    output logic [DATA_W-1:0] o_inst_out,
    output logic              o_inst_valid,
    output logic              o_inst_fault,
    output logic [31:0]       o_fetch_count
);

    localparam int DEPTH = 2 ** ADDR_W;

    // The memory array has no reset. Every word starts as the bubble
    // instruction, so an unloaded word executes as a harmless nop.
    logic [DATA_W-1:0] r_mem [DEPTH] = '{default: NOP_WORD};

    logic [DATA_W-1:0] r_inst_out;
    logic              r_inst_valid;
    logic              r_inst_fault;
    logic [31:0]       r_fetch_count;

    logic [ADDR_W-1:0] w_word_idx;
    logic              w_misaligned;
    logic              w_out_of_range;
    logic              w_fault;
    logic              w_accept;
    logic              w_bypass;
    logic [DATA_W-1:0] w_mem_word;

    assign w_word_idx     = i_fetch_addr[ADDR_W+1:2];
    assign w_misaligned   = |i_fetch_addr[1:0];
    assign w_out_of_range = |i_fetch_addr[31:ADDR_W+2];
    assign w_fault        = w_misaligned | w_out_of_range;
    assign w_accept       = i_fetch_req & ~i_stall & ~i_flush;

    // A loader write to the word being fetched in the same cycle is forwarded.
    // The fetch therefore sees the new data (write-first behaviour).
    assign w_bypass   = i_prog_we && (i_prog_addr == w_word_idx);
    assign w_mem_word = w_bypass ? i_prog_data : r_mem[w_word_idx];

    // Loader writes land at the clock edge whatever stall or flush are doing.
    always_ff @(posedge i_clk) begin
        if (i_prog_we) begin
            r_mem[i_prog_addr] <= i_prog_data;
        end
    end

    // Output stage. Flush beats stall, stall beats a fetch, and an idle
    // cycle loads a non-valid bubble.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_inst_out   <= NOP_WORD;
            r_inst_valid <= 1'b0;
            r_inst_fault <= 1'b0;
        end else if (i_flush) begin
            r_inst_out   <= NOP_WORD;
            r_inst_valid <= 1'b0;
            r_inst_fault <= 1'b0;
        end else if (i_stall) begin
            r_inst_out   <= r_inst_out;
            r_inst_valid <= r_inst_valid;
            r_inst_fault <= r_inst_fault;
        end else if (i_fetch_req) begin
            if (w_fault) begin
                r_inst_out   <= NOP_WORD;
                r_inst_valid <= 1'b1;
                r_inst_fault <= 1'b1;
            end else begin
                r_inst_out   <= w_mem_word;
                r_inst_valid <= 1'b1;
                r_inst_fault <= 1'b0;
            end
        end else begin
            r_inst_out   <= NOP_WORD;
            r_inst_valid <= 1'b0;
            r_inst_fault <= 1'b0;
        end
    end

    // Count accepted fetches, including faulting ones.
    // The count sticks at all-ones instead of wrapping.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fetch_count <= FETCH_COUNT_RST;
        end else if (w_accept && (r_fetch_count != 32'hFFFFFFFF)) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign o_inst_out    = r_inst_out;
    assign o_inst_valid  = r_inst_valid;
    assign o_inst_fault  = r_inst_fault;
    assign o_fetch_count = r_fetch_count;

endmodule

// File: tb/tb_inst_mem_sync.sv
// Directed, table-driven bench for inst_mem_sync.
// A second instance starts its counter near the top, so saturation is reached in a few fetches.
module tb_inst_mem_sync;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
    localparam logic [31:0] NOP = 32'h00000013;

    logic              clock;
    logic              reset;
    logic              fetchReq;
    logic [31:0]       fetchAddr;
    logic              stall;
    logic              flush;
    logic              progWe;
    logic [ADDR_W-1:0] progAddr;
    logic [DATA_W-1:0] progData;
    logic [DATA_W-1:0] instOut;
    logic              instValid;
    logic              instFault;
    logic [31:0]       fetchCount;
    logic [DATA_W-1:0] satInstOut;
    logic              satInstValid;
    logic              satInstFault;
    logic [31:0]       satFetchCount;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic              req;
        logic [31:0]       addr;
        logic              stl;
        logic              fl;
        logic              we;
        logic [ADDR_W-1:0] pAddr;
        logic [DATA_W-1:0] pData;
        logic [DATA_W-1:0] expOut;
        logic              expValid;
        logic              expFault;
        logic [31:0]       expCount;
    } vec_t;

    localparam int NVEC = 28;
    vec_t vecs [NVEC];

    inst_mem_sync #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NOP_WORD(NOP)) dut (
        .i_clk(clock), .i_rst(reset), .i_fetch_req(fetchReq), .i_fetch_addr(fetchAddr),
        .i_stall(stall), .i_flush(flush), .i_prog_we(progWe), .i_prog_addr(progAddr),
        .i_prog_data(progData), .o_inst_out(instOut), .o_inst_valid(instValid),
        .o_inst_fault(instFault), .o_fetch_count(fetchCount)
    );

    inst_mem_sync #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NOP_WORD(NOP),
                    .FETCH_COUNT_RST(32'hFFFFFFFC)) dutSat (
        .i_clk(clock), .i_rst(reset), .i_fetch_req(fetchReq), .i_fetch_addr(fetchAddr),
        .i_stall(stall), .i_flush(flush), .i_prog_we(progWe), .i_prog_addr(progAddr),
        .i_prog_data(progData), .o_inst_out(satInstOut), .o_inst_valid(satInstValid),
        .o_inst_fault(satInstFault), .o_fetch_count(satFetchCount)
    );

    // Free-running clock, 10 time units per period
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Compare a single value and record the outcome
    task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Compare the full output stage and the main counter
    task automatic checkOutput(input string name, input logic [31:0] eOut, input logic eValid,
                               input logic eFault, input logic [31:0] eCount);
        checkValue({name, ".inst_out"}, instOut, eOut);
        checkValue({name, ".inst_valid"}, {31'd0, instValid}, {31'd0, eValid});
        checkValue({name, ".inst_fault"}, {31'd0, instFault}, {31'd0, eFault});
        checkValue({name, ".fetch_count"}, fetchCount, eCount);
    endtask

    // Drive one vector's inputs, then sample just after the next rising edge
    task automatic applyStimulus(input vec_t v);
        fetchReq  = v.req;
        fetchAddr = v.addr;
        stall     = v.stl;
        flush     = v.fl;
        progWe    = v.we;
        progAddr  = v.pAddr;
        progData  = v.pData;
        @(posedge clock);
        #1;
    endtask

    // Issue a plain legal fetch and sample after the edge
    task automatic fetchOnce(input logic [31:0] addr);
        fetchReq = 1'b1; fetchAddr = addr; stall = 1'b0; flush = 1'b0; progWe = 1'b0;
        @(posedge clock);
        #1;
    endtask

    initial begin
        //          req  addr          stl   fl    we    pA     pData           expOut          v     f     cnt
        vecs[0]  = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 6'd0, 32'h00500093, NOP,          1'b0, 1'b0, 32'd0};
        vecs[1]  = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 6'd1, 32'hffc00113, NOP,          1'b0, 1'b0, 32'd0};
        vecs[2]  = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 6'd2, 32'h00108463, NOP,          1'b0, 1'b0, 32'd0};
        vecs[3]  = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 6'd3, 32'h00a00193, NOP,          1'b0, 1'b0, 32'd0};
        vecs[4]  = '{1'b1, 32'h0,   1'b0, 1'b0, 1'b0, 6'd0, 32'h0,        32'h00500093, 1'b1, 1'b0, 32'd1};
        vecs[5]  = '{1'b1, 32'h4,   1'b0, 1'b0, 1'b0, 6'd0, 32'h0,        32'hffc00113, 1'b1, 1'b0, 32'd2};
        vecs[6]  = '{1'b1, 32'h8,   1'b0, 1'b0, 1'b0, 6'd0, 32'h0,        32'h00108463, 1'b1, 1'b0, 32'd3};
        vecs[7]  = '{1'b1, 32'hC,   1'b0, 1'b0, 1'b0, 6'd0, 32'h0,        32'h00a00193, 1'b1, 1'b0, 32'd4};
        vecs[8]  = '{1'b1, 32'h4,   1'b0, 1'b0, 1'b0, 6'd0, 32'h0,        32'hffc00113, 1'b1, 1'b0, 32'd5};
        vecs[9]  = '{1'b1, 32'h8,   1'b1, 1'b0, 1'b0, 6'd0, 32'h0,        32'hffc00113, 1'b1, 1'b0, 32'd5};
        vecs[10] = '{1'b1, 32'h8,   1'b1, 1'b0, 1'b0, 6'd0, 32'h0,        32'hffc00113, 1'b1, 1'b0, 32'd5};
        vecs[11] = '{1'b1, 32'h8,   1'b1, 1'b0, 1'b0, 6'd0, 32'h0,        32'hffc00113, 1'b1, 1'b0, 32'd5};
        vecs[12] = '{1'b1, 32'h8,   1'b0, 1'b0, 1'b0, 6'd0, 32'h0,        32'h00108463, 1'b1, 1'b0, 32'd6};
        vecs[13] = '{1'b1, 32'h2,   1'b0, 1'b0, 1'b0, 6'd0, 32'h0,        NOP,          1'b1, 1'b1, 32'd7};
        vecs[14] = '{1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0,        NOP,          1'b1, 1'b1, 32'd8};
        vecs[15] = '{1'b1, 32'h14,  1'b0, 1'b0, 1'b1, 6'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b0, 32'd9};
        vecs[16] = '{1'b1, 32'h14,  1'b1, 1'b1, 1'b0, 6'd0, 32'h0,        NOP,          1'b0, 1'b0, 32'd9};
        vecs[17] = '{1'b1, 32'h14,  1'b0, 1'b0, 1'b0, 6'd0, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 32'd10};
        vecs[18] = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 6'd0, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 32'd10};
        vecs[19] = '{1'b1, 32'h18,  1'b0, 1'b1, 1'b1, 6'd6, 32'h12345678, NOP,          1'b0, 1'b0, 32'd10};
        vecs[20] = '{1'b1, 32'h18,  1'b0, 1'b0, 1'b0, 6'd0, 32'h0,        32'h12345678, 1'b1, 1'b0, 32'd11};
        vecs[21] = '{1'b1, 32'hFC,  1'b0, 1'b0, 1'b0, 6'd0, 32'h0,        NOP,          1'b1, 1'b0, 32'd12};
        vecs[22] = '{1'b1, 32'h3,   1'b0, 1'b0, 1'b0, 6'd0, 32'h0,        NOP,          1'b1, 1'b1, 32'd13};
        vecs[23] = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 6'd0, 32'h0,        NOP,          1'b0, 1'b0, 32'd13};
        vecs[24] = '{1'b1, 32'h101, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0,        NOP,          1'b1, 1'b1, 32'd14};
        vecs[25] = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 6'd0, 32'h0,        NOP,          1'b1, 1'b1, 32'd14};
        vecs[26] = '{1'b1, 32'h1C,  1'b1, 1'b0, 1'b1, 6'd7, 32'hCAFEF00D, NOP,          1'b1, 1'b1, 32'd14};
        vecs[27] = '{1'b1, 32'h1C,  1'b0, 1'b0, 1'b0, 6'd0, 32'h0,        32'hCAFEF00D, 1'b1, 1'b0, 32'd15};

        reset = 1'b1; fetchReq = 1'b0; fetchAddr = 32'h0; stall = 1'b0; flush = 1'b0;
        progWe = 1'b0; progAddr = '0; progData = '0;
        #1;
        checkOutput("reset", NOP, 1'b0, 1'b0, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), vecs[i].expOut, vecs[i].expValid,
                        vecs[i].expFault, vecs[i].expCount);
        end

        // Reset mid-cycle with a request pending: outputs clear without a clock edge
        fetchReq = 1'b1; fetchAddr = 32'h0; stall = 1'b0; flush = 1'b0; progWe = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("asyncReset", NOP, 1'b0, 1'b0, 32'd0);
        checkValue("asyncReset.satCount", satFetchCount, 32'hFFFFFFFC);

        // A request held across an edge during reset is lost
        fetchAddr = 32'h4;
        @(posedge clock);
        #1;
        checkOutput("heldReset", NOP, 1'b0, 1'b0, 32'd0);

        // A request presented as reset drops is taken at the first free edge.
        // Memory written before the reset is still intact.
        reset = 1'b0;
        fetchOnce(32'h4);
        checkOutput("postReset0", 32'hffc00113, 1'b1, 1'b0, 32'd1);
        checkValue("postReset0.satCount", satFetchCount, 32'hFFFFFFFD);
        fetchOnce(32'h18);
        checkOutput("postReset1", 32'h12345678, 1'b1, 1'b0, 32'd2);
        checkValue("postReset1.satCount", satFetchCount, 32'hFFFFFFFE);

        // Three more fetches: the saturating counter pins at all-ones
        for (int k = 0; k < 3; k++) begin
            fetchOnce(32'h14);
            checkValue($sformatf("sat%0d.count", k), satFetchCount, 32'hFFFFFFFF);
            checkValue($sformatf("sat%0d.inst_out", k), satInstOut, 32'hDEADBEEF);
        end
        checkValue("mainCountAfterSat", fetchCount, 32'd5);

        fetchReq = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_mem_sync.md
INST_MEM_SYNC -- requirements
Module: inst_mem_sync

Interface
REQ-001 The block SHALL provide parameter ADDR_W, default 6, meaning number of word-index bits; depth = 2**ADDR_W words.
REQ-002 The block SHALL provide parameter DATA_W, default 32, meaning instruction word width.
REQ-003 The block SHALL provide parameter NOP_WORD, default 32'h00000013 (addi x0,x0,0), meaning the bubble value driven when no valid instruction is present.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 fetch_req  input  1  fetch request for fetch_addr this cycle.
REQ-007 fetch_addr  input  32  byte address (PC).
REQ-008 stall  input  1  hold the output stage unchanged.
REQ-009 flush  input  1  discard the output stage and any request this cycle.
REQ-010 prog_we  input  1  loader write enable.
REQ-011 prog_addr  input  ADDR_W  loader word index.
REQ-012 prog_data  input  DATA_W  loader write data.
REQ-013 inst_out  output  DATA_W  registered instruction.
REQ-014 inst_valid  output  1  inst_out holds a fetched instruction.
REQ-015 inst_fault  output  1  the instruction in the output stage came from a misaligned or out-of-range address.
REQ-016 fetch_count  output  32  saturating count of accepted fetches.

Function
REQ-017 Memory SHALL be 2**ADDR_W x DATA_W, initialised at elaboration with every word = NOP_WORD; memory contents are not reset.
REQ-018 Word index SHALL be fetch_addr[ADDR_W+1:2].
REQ-019 A fetch SHALL be accepted when fetch_req=1, stall=0 and flush=0.
REQ-020 Read latency SHALL be exactly 1 cycle: an accepted fetch at edge N updates inst_out/inst_valid/inst_fault after edge N.
REQ-021 Misaligned (fetch_addr[1:0]!=0) or out-of-range (fetch_addr[31:ADDR_W+2]!=0) accepted fetches SHALL load inst_out=NOP_WORD, inst_valid=1, inst_fault=1.
REQ-022 Legal accepted fetches SHALL load the memory word, inst_valid=1, inst_fault=0.
REQ-023 If fetch_req=0, stall=0 and flush=0, the output stage SHALL load inst_out=NOP_WORD, inst_valid=0, inst_fault=0.
REQ-024 stall=1 with flush=0 SHALL hold inst_out, inst_valid and inst_fault unchanged and SHALL NOT accept a fetch.
REQ-025 flush=1 SHALL take priority over stall and fetch_req: output stage loads NOP_WORD, inst_valid=0, inst_fault=0.
REQ-026 prog_we=1 SHALL write prog_data to mem[prog_addr] at the clock edge, independent of stall/flush.
REQ-027 Write and accepted legal fetch to the same word in the same cycle SHALL be write-first: inst_out receives prog_data.
REQ-028 fetch_count SHALL increment by 1 per accepted fetch (faulting included) and saturate at 32'hFFFFFFFF.

Reset
REQ-029 While rst=1, asynchronously: inst_out=NOP_WORD, inst_valid=0, inst_fault=0, fetch_count=0.
REQ-030 A fetch presented during the cycle rst deasserts SHALL be accepted at the first rising edge with rst=0; a request in flight when rst asserts is lost.
REQ-031 Reset SHALL NOT alter memory contents; words written via prog_we before reset remain readable after.

Verification
REQ-032 Load mem[0..3] via prog port with 0x00500093, 0xffc00113, 0x00108463, 0x00a00193; fetch 0x0,0x4,0x8,0xC back-to-back -> same words one cycle later each, inst_valid=1, fetch_count=4.
REQ-033 Fetch 0x4 then stall for 3 cycles with fetch_req=1, addr 0x8 -> inst_out stays 0xffc00113, fetch_count +1 only; after stall release 0x00108463 appears.
REQ-034 Fetch 0x2 -> inst_fault=1, inst_out=0x00000013; fetch 0x100 with ADDR_W=6 -> inst_fault=1; both counted.
REQ-035 prog_we to word 5 with 0xDEADBEEF and fetch 0x14 same cycle -> inst_out=0xDEADBEEF next cycle.
REQ-036 flush and stall together with valid output -> inst_valid=0, inst_out=0x00000013 next cycle; assert rst mid-stream -> outputs reset immediately without clock, prior memory writes still read back.
REQ-037 Force fetch_count to 0xFFFFFFFE via continuous fetches (or with a parameterised/forced counter) then 3 fetches -> fetch_count=0xFFFFFFFF, no wrap.
